// File: rtl/raw_scoreboard.sv
// ---------------------------------------------------------------------------
// raw_scoreboard
//
// Purpose:
//   Sits beside the ID stage and tracks destinations of long-latency
//   producers (loads, multi-cycle ALU ops) whose data cannot be forwarded
//   until writeback. An instruction in ID that reads or overwrites such a
//   register stalls until the producer retires. The block also caps the
//   number of in-flight long ops, counts stall cycles, and flags writebacks
//   that do not match any tracked producer.
//
// Ports:
//   clk            pipeline clock
//   rst_n          asynchronous active-low reset
//   id_valid_i     ID holds a valid instruction
//   id_rs1_re_i    instruction reads rs1
//   id_rs1_addr_i  rs1 index
//   id_rs2_re_i    instruction reads rs2
//   id_rs2_addr_i  rs2 index
//   id_rd_we_i     instruction writes rd
//   id_rd_addr_i   rd index
//   id_long_i      result is produced late (not forwardable before WB)
//   flush_i        ID instruction is being killed
//   wb_done_i      a long-latency result is written back this cycle
//   wb_addr_i      register index of that result
//   stall_req_o    hold PC/IF/ID, insert bubble into EX
//   issue_fire_o   ID instruction advances this cycle
//   pending_o      per-register pending bits, bit 0 always 0
//   outstanding_o  number of tracked long ops
//   stall_cnt_o    saturating count of stall cycles
//   err_o          sticky protocol error
// ---------------------------------------------------------------------------
module raw_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic             id_rs1_re_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs2_re_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rd_we_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_long_i,
    input  logic             flush_i,
    input  logic             wb_done_i,
    input  logic [4:0]       wb_addr_i,
    output logic             stall_req_o,
    output logic             issue_fire_o,
    output logic [31:0]      pending_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic [31:0]      stall_cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [31:0]      stallCnt_q, stallCnt_d;
    logic             err_q, err_d;

    logic wbOk;
    logic rs1Haz;
    logic rs2Haz;
    logic wawHaz;
    logic capHaz;
    logic stallReq;
    logic issueFire;
    logic track;

    // Hazard detection. A writeback to the same index in this cycle releases
    // the consumer because the forwarding unit's WB path supplies the data.
    // The capacity check lets a new long op in when a slot frees this cycle.
    always_comb begin
        wbOk   = wb_done_i && (wb_addr_i != 5'd0) && pending_q[wb_addr_i];
        rs1Haz = id_rs1_re_i && (id_rs1_addr_i != 5'd0) && pending_q[id_rs1_addr_i]
                 && !(wb_done_i && (wb_addr_i == id_rs1_addr_i));
        rs2Haz = id_rs2_re_i && (id_rs2_addr_i != 5'd0) && pending_q[id_rs2_addr_i]
                 && !(wb_done_i && (wb_addr_i == id_rs2_addr_i));
        wawHaz = id_rd_we_i && (id_rd_addr_i != 5'd0) && pending_q[id_rd_addr_i]
                 && !(wb_done_i && (wb_addr_i == id_rd_addr_i));
        capHaz = id_long_i && id_rd_we_i && (id_rd_addr_i != 5'd0)
                 && (outstanding_q == MaxCnt) && !wbOk;

        stallReq  = id_valid_i && !flush_i && (rs1Haz || rs2Haz || wawHaz || capHaz);
        issueFire = id_valid_i && !flush_i && !stallReq;
        track     = issueFire && id_long_i && id_rd_we_i && (id_rd_addr_i != 5'd0);
    end

    // Next-state for the scoreboard. Retire clears first and track sets
    // afterwards, so a same-index retire+track leaves the register pending.
    // Bit 0 is forced low because x0 never holds a real result.
    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        stallCnt_d    = stallCnt_q;
        err_d         = err_q;

        if (wbOk) begin
            pending_d[wb_addr_i] = 1'b0;
        end
        if (track) begin
            pending_d[id_rd_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (track && !wbOk) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (wbOk && !track) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (stallReq && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end

        if (wb_done_i && !wbOk) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset. All in-flight
    // tracking is dropped on reset since the pipeline resets alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= 32'd0;
            outstanding_q <= '0;
            stallCnt_q    <= 32'd0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stallCnt_q    <= stallCnt_d;
            err_q         <= err_d;
        end
    end

    // Output mapping.
    always_comb begin
        stall_req_o   = stallReq;
        issue_fire_o  = issueFire;
        pending_o     = pending_q;
        outstanding_o = outstanding_q;
        stall_cnt_o   = stallCnt_q;
        err_o         = err_q;
    end

endmodule

// File: tb/tb_raw_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_raw_scoreboard
//
// Purpose:
//   Directed self-checking bench for raw_scoreboard. Inputs change #1 after
//   the rising edge; combinational outputs are checked before the next edge
//   and registered outputs are checked #1 after the edge.
// ---------------------------------------------------------------------------
module tb_raw_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic        id_rs1_re_i;
    logic [4:0]  id_rs1_addr_i;
    logic        id_rs2_re_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rd_we_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_long_i;
    logic        flush_i;
    logic        wb_done_i;
    logic [4:0]  wb_addr_i;
    logic        stall_req_o;
    logic        issue_fire_o;
    logic [31:0] pending_o;
    logic [2:0]  outstanding_o;
    logic [31:0] stall_cnt_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    raw_scoreboard #(
        .MAX_OUTSTANDING(4),
        .CNT_W(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid_i),
        .id_rs1_re_i   (id_rs1_re_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_re_i   (id_rs2_re_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rd_we_i    (id_rd_we_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_long_i     (id_long_i),
        .flush_i       (flush_i),
        .wb_done_i     (wb_done_i),
        .wb_addr_i     (wb_addr_i),
        .stall_req_o   (stall_req_o),
        .issue_fire_o  (issue_fire_o),
        .pending_o     (pending_o),
        .outstanding_o (outstanding_o),
        .stall_cnt_o   (stall_cnt_o),
        .err_o         (err_o)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID-stage instruction plus the writeback port in one call.
    task automatic applyStimulus(
        input logic       valid,
        input logic       rs1Re, input logic [4:0] rs1,
        input logic       rs2Re, input logic [4:0] rs2,
        input logic       rdWe,  input logic [4:0] rd,
        input logic       isLong,
        input logic       flush,
        input logic       wbDone, input logic [4:0] wbAddr
    );
        id_valid_i    = valid;
        id_rs1_re_i   = rs1Re;
        id_rs1_addr_i = rs1;
        id_rs2_re_i   = rs2Re;
        id_rs2_addr_i = rs2;
        id_rd_we_i    = rdWe;
        id_rd_addr_i  = rd;
        id_long_i     = isLong;
        flush_i       = flush;
        wb_done_i     = wbDone;
        wb_addr_i     = wbAddr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state, with a valid instruction in ID during reset.
        rst_n = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("rst_pending",     pending_o, 32'd0);
        checkOutput("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
        checkOutput("rst_stallcnt",    stall_cnt_o, 32'd0);
        checkOutput("rst_err",         {31'd0, err_o}, 32'd0);
        checkOutput("rst_stall",       {31'd0, stall_req_o}, 32'd0);
        checkOutput("rst_issue",       {31'd0, issue_fire_o}, 32'd1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load to x5, dependent reader stalls two cycles, released by WB.
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        checkOutput("ld5_issue", {31'd0, issue_fire_o}, 32'd1);
        tick();
        checkOutput("ld5_pending", pending_o, 32'h0000_0020);
        checkOutput("ld5_outstanding", {29'd0, outstanding_o}, 32'd1);
        applyStimulus(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        checkOutput("use5_stall1", {31'd0, stall_req_o}, 32'd1);
        checkOutput("use5_issue1", {31'd0, issue_fire_o}, 32'd0);
        tick();
        checkOutput("use5_stall2", {31'd0, stall_req_o}, 32'd1);
        tick();
        applyStimulus(1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 5);
        checkOutput("use5_release_stall", {31'd0, stall_req_o}, 32'd0);
        checkOutput("use5_release_issue", {31'd0, issue_fire_o}, 32'd1);
        tick();
        idle();
        checkOutput("use5_pending_clr", pending_o, 32'd0);
        checkOutput("use5_outstanding", {29'd0, outstanding_o}, 32'd0);
        checkOutput("use5_stallcnt", stall_cnt_o, 32'd2);

        // Long op to x0 is never tracked; reading x0 never stalls.
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        checkOutput("x0_issue", {31'd0, issue_fire_o}, 32'd1);
        tick();
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_read_stall", {31'd0, stall_req_o}, 32'd0);
        checkOutput("x0_pending", pending_o, 32'd0);
        checkOutput("x0_outstanding", {29'd0, outstanding_o}, 32'd0);
        tick();

        // Fill all four slots, then a fifth long op waits for a free slot.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 5'(i), 1, 0, 0, 0);
            tick();
        end
        checkOutput("cap_outstanding_full", {29'd0, outstanding_o}, 32'd4);
        checkOutput("cap_pending_full", pending_o, 32'h0000_001E);
        applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        checkOutput("cap_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        checkOutput("cap_stallcnt", stall_cnt_o, 32'd3);
        applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 0, 1, 1);
        checkOutput("cap_release_issue", {31'd0, issue_fire_o}, 32'd1);
        tick();
        idle();
        checkOutput("cap_outstanding_after", {29'd0, outstanding_o}, 32'd4);
        checkOutput("cap_pending_after", pending_o, 32'h0000_005C);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6); tick();
        idle();
        checkOutput("cap_drained", {29'd0, outstanding_o}, 32'd0);
        checkOutput("cap_drained_err", {31'd0, err_o}, 32'd0);

        // Retire x7 and re-track x7 in the same cycle: set wins.
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 7);
        checkOutput("x7_reissue", {31'd0, issue_fire_o}, 32'd1);
        tick();
        idle();
        checkOutput("x7_pending", pending_o, 32'h0000_0080);
        checkOutput("x7_outstanding", {29'd0, outstanding_o}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        idle();
        checkOutput("x7_retired", {29'd0, outstanding_o}, 32'd0);

        // Flushed consumer of pending x9: no stall, no fire, bit stays.
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        checkOutput("x9_nofl_stall", {31'd0, stall_req_o}, 32'd1);
        applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0);
        checkOutput("x9_fl_stall", {31'd0, stall_req_o}, 32'd0);
        checkOutput("x9_fl_issue", {31'd0, issue_fire_o}, 32'd0);
        tick();
        idle();
        checkOutput("x9_pending", pending_o, 32'h0000_0200);
        checkOutput("x9_stallcnt", stall_cnt_o, 32'd3);

        // Writeback of non-pending x12 raises a sticky error.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
        tick();
        idle();
        checkOutput("x12_err", {31'd0, err_o}, 32'd1);
        checkOutput("x12_outstanding", {29'd0, outstanding_o}, 32'd1);
        checkOutput("x12_pending", pending_o, 32'h0000_0200);
        tick();
        checkOutput("x12_err_sticky", {31'd0, err_o}, 32'd1);

        // WAW on pending x9 stalls; reset asserted mid-stall clears all.
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        checkOutput("waw_stall", {31'd0, stall_req_o}, 32'd1);
        tick();
        checkOutput("waw_stallcnt", stall_cnt_o, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pending", pending_o, 32'd0);
        checkOutput("midrst_outstanding", {29'd0, outstanding_o}, 32'd0);
        checkOutput("midrst_stallcnt", stall_cnt_o, 32'd0);
        checkOutput("midrst_err", {31'd0, err_o}, 32'd0);
        checkOutput("midrst_stall", {31'd0, stall_req_o}, 32'd0);
        checkOutput("midrst_issue", {31'd0, issue_fire_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
